product_accum: RTL and testbench
================================

# product_accum

Downstream consumer of the pipelined 4-bit multiplier. Captures each 8-bit `product` on its `done` pulse and sums a fixed group of COUNT products into a wider accumulator. Presents the finished sum on a valid/ready output handshake. Provides one-deep buffering so the multiplier can keep issuing while the result waits for the consumer.

## Interface
- PROD_W, 8: product width; matches the multiplier output.
- ACC_W, 16: accumulator/result width; must be ≥ PROD_W.
- COUNT, 4: products per group; must be ≥ 1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while 0.
- product  input  PROD_W  multiplier result, valid only when done=1.
- done  input  1  product-valid strobe, sampled every rising edge; every high cycle is one product.
- acc_out  output  ACC_W  group sum; stable while out_valid=1.
- out_valid  output  1  acc_out holds a completed group.
- out_ready  input  1  consumer accepts; transfer happens on an edge where out_valid && out_ready.
- overflow  output  1  the group in acc_out exceeded 2^ACC_W−1; qualified by out_valid.
- busy  output  1  a group is partially accumulated (state ACCUM).
- drop_err  output  1  sticky flag: a product was lost; cleared only by reset.

## Operation
- States: IDLE, ACCUM, HOLD. All outputs are 0 at reset: acc_out=0, out_valid=0, overflow=0, busy=0, drop_err=0, count=0, pending empty.
- IDLE, done=1: acc ← product, count ← 1. Go to HOLD if COUNT=1, otherwise to ACCUM.
- ACCUM, done=1: acc ← acc + product (zero-extended), count ← count+1. Go to HOLD when count reaches COUNT.
- HOLD: out_valid=1 and acc_out is frozen.
  - done=1 with no transfer: product goes to the one-entry pending register.
  - done=1 while pending is already full: the product is discarded and drop_err is set.
- Transfer edge (HOLD && out_ready):
  - If done=1: the new product starts the next group. A full pending slot cannot coexist with this; pending is drained first, so a full pending plus done sends the pending value to acc and the done product to pending.
  - Else if pending is full: acc ← pending, count ← 1, pending is cleared.
  - Else: go to IDLE with acc cleared.
  - The next state follows the same COUNT=1 rule as IDLE.
- Overflow: set when any addition in the group carries out of ACC_W. It is cleared at the first product of the next group.
- Arithmetic is unsigned. The count register is $clog2(COUNT+1) bits wide.

## Timing
- Registered outputs only; there is no combinational path from any input to any output.
- The COUNT-th done sampled at edge k gives out_valid=1 and the final acc_out after edge k, one cycle of latency.
- With out_ready held at 1, the minimum residency in HOLD is one cycle, which allows a back-to-back group every COUNT cycles with no bubbles.
- reset asserted mid-group or in HOLD: everything returns to reset values immediately; partial sums and pending are lost, and drop_err is cleared.
- done is ignored while reset=0.

## Configuration
- PRODUCT_ACCUM_SAT_EN defined: on overflow, acc clamps to 2^ACC_W−1 and stays there for the rest of the group; overflow=1.
- PRODUCT_ACCUM_SAT_EN undefined: the sum wraps modulo 2^ACC_W; overflow=1.

## Structure
- Package product_accum_pkg holds:
  - the state enum (IDLE/ACCUM/HOLD);
  - default PROD_W/ACC_W/COUNT localparams.
- Sub-module accum_adder: a combinational ACC_W adder with carry-out and the macro-selected saturate/wrap result. It is instantiated once and reused for both the ACCUM and the pending-to-acc paths.

## Test plan
- COUNT=4, ACC_W=16, out_ready=1; products 32, 3, 225, 9 on consecutive done cycles → out_valid for 1 cycle with acc_out=269, overflow=0.
- ACC_W=9, four products of 255:
  - without PRODUCT_ACCUM_SAT_EN → acc_out=508, overflow=1;
  - with PRODUCT_ACCUM_SAT_EN → acc_out=511, overflow=1.
- out_ready=0 after a completed group (sum 10):
  - one extra done with product=7 → pending filled, acc_out stays 10;
  - raise out_ready → next group starts with acc=7, count=1;
  - a second extra done before the raise → drop_err=1.
- Continuous done with out_ready=1, COUNT=2, products 1,2,3,4 → results 3 then 7 on consecutive groups with no lost product.
- reset driven low after 2 of 4 products → all outputs 0 while low; after release, a fresh group 5,5,5,5 → acc_out=20.
- COUNT=1, product=144 → out_valid the next cycle with acc_out=144.

Source files
------------

// File: rtl/product_accum_pkg.sv
// Shared types and default sizing for the product accumulator.
package product_accum_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_COUNT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/product_accum_adder.sv
// Accumulator adder with carry-out; result saturates when PRODUCT_ACCUM_SAT_EN
// is defined, otherwise wraps modulo 2^ACC_W.
module accum_adder
    import product_accum_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] raw_s;

    // Zero-extended add, then wrap or clamp depending on the build.
    always_comb begin
        raw_s = {1'b0, a} + {{(ACC_W - PROD_W + 1){1'b0}}, b};
        carry = raw_s[ACC_W];
`ifdef PRODUCT_ACCUM_SAT_EN
        if (raw_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
        end else begin
            sum = raw_s[ACC_W-1:0];
        end
`else
        sum = raw_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accum.sv
// Sums groups of COUNT multiplier products and presents each sum on a
// valid/ready port with a one-entry overflow buffer. Optional: PRODUCT_ACCUM_SAT_EN.
module product_accum
    import product_accum_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int COUNT  = DEF_COUNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] product,
    input  logic              done,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy,
    output logic              drop_err
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COUNT);
    localparam state_e FIRST_ST = (COUNT == 1) ? ST_HOLD : ST_ACCUM;

    state_e             state_r, state_n;
    logic [ACC_W-1:0]   acc_r, acc_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic               ovf_r, ovf_n;
    logic [PROD_W-1:0]  pend_r, pend_n;
    logic               pv_r, pv_n;
    logic               drop_r, drop_n;
    logic               valid_r, busy_r;

    logic [ACC_W-1:0]   add_a_s;
    logic [PROD_W-1:0]  add_b_s;
    logic [ACC_W-1:0]   sum_s;
    logic               carry_s;

    // A new group starts from zero; a waiting pending product takes priority over done.
    always_comb begin
        if ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready)) begin
            add_a_s = {ACC_W{1'b0}};
        end else begin
            add_a_s = acc_r;
        end
        if ((state_r == ST_HOLD) && pv_r) begin
            add_b_s = pend_r;
        end else begin
            add_b_s = product;
        end
    end

    accum_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_adder (
        .a     (add_a_s),
        .b     (add_b_s),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // Next-state and datapath update.
    always_comb begin
        state_n = state_r;
        acc_n   = acc_r;
        cnt_n   = cnt_r;
        ovf_n   = ovf_r;
        pend_n  = pend_r;
        pv_n    = pv_r;
        drop_n  = drop_r;
        case (state_r)
            ST_IDLE: begin
                if (done) begin
                    acc_n   = sum_s;
                    cnt_n   = CNT_ONE;
                    ovf_n   = 1'b0;
                    state_n = FIRST_ST;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (done) begin
                    acc_n = sum_s;
                    cnt_n = cnt_r + CNT_ONE;
                    ovf_n = ovf_r | carry_s;
                    if ((cnt_r + CNT_ONE) == CNT_FULL) begin
                        state_n = ST_HOLD;
                    end else begin
                        state_n = ST_ACCUM;
                    end
                end else begin
                    state_n = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (pv_r || done) begin
                        // Pending drains first; a concurrent done refills the slot.
                        acc_n   = sum_s;
                        cnt_n   = CNT_ONE;
                        ovf_n   = 1'b0;
                        state_n = FIRST_ST;
                        pv_n    = pv_r && done;
                        pend_n  = product;
                    end else begin
                        acc_n   = {ACC_W{1'b0}};
                        cnt_n   = {CNT_W{1'b0}};
                        ovf_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                end else if (done) begin
                    if (pv_r) begin
                        drop_n = 1'b1;
                    end else begin
                        pend_n = product;
                        pv_n   = 1'b1;
                    end
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; status flags track the next state so they are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            pend_r  <= {PROD_W{1'b0}};
            pv_r    <= 1'b0;
            drop_r  <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            acc_r   <= acc_n;
            cnt_r   <= cnt_n;
            ovf_r   <= ovf_n;
            pend_r  <= pend_n;
            pv_r    <= pv_n;
            drop_r  <= drop_n;
            valid_r <= (state_n == ST_HOLD);
            busy_r  <= (state_n == ST_ACCUM);
        end
    end

    assign acc_out   = acc_r;
    assign out_valid = valid_r;
    assign overflow  = ovf_r;
    assign busy      = busy_r;
    assign drop_err  = drop_r;

endmodule

// File: tb/tb_product_accum.sv
// Self-checking bench: four product_accum configurations share one stimulus
// stream and are compared every cycle against a group-list reference model.
module tb_product_accum;

    localparam int N = 4;
    localparam int CNT_P  [N] = '{4, 4, 1, 2};
    localparam int ACCW_P [N] = '{16, 9, 16, 16};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        done = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  product = 8'd0;
    logic [15:0] acc_a, acc_c, acc_d;
    logic [8:0]  acc_b;
    logic [N-1:0] ov_v, of_v, bz_v, de_v;

    int n_checks = 0;
    int n_fail   = 0;

    int grp_q  [N][$];
    int pend_q [N][$];
    bit drop_m [N];

    always #5 clk = ~clk;

    product_accum #(.PROD_W(8), .ACC_W(16), .COUNT(4)) u_a (
        .clk(clk), .reset(reset), .product(product), .done(done), .acc_out(acc_a),
        .out_valid(ov_v[0]), .out_ready(out_ready), .overflow(of_v[0]), .busy(bz_v[0]), .drop_err(de_v[0]));
    product_accum #(.PROD_W(8), .ACC_W(9), .COUNT(4)) u_b (
        .clk(clk), .reset(reset), .product(product), .done(done), .acc_out(acc_b),
        .out_valid(ov_v[1]), .out_ready(out_ready), .overflow(of_v[1]), .busy(bz_v[1]), .drop_err(de_v[1]));
    product_accum #(.PROD_W(8), .ACC_W(16), .COUNT(1)) u_c (
        .clk(clk), .reset(reset), .product(product), .done(done), .acc_out(acc_c),
        .out_valid(ov_v[2]), .out_ready(out_ready), .overflow(of_v[2]), .busy(bz_v[2]), .drop_err(de_v[2]));
    product_accum #(.PROD_W(8), .ACC_W(16), .COUNT(2)) u_d (
        .clk(clk), .reset(reset), .product(product), .done(done), .acc_out(acc_d),
        .out_valid(ov_v[3]), .out_ready(out_ready), .overflow(of_v[3]), .busy(bz_v[3]), .drop_err(de_v[3]));

    function automatic int acc_of(input int i);
        case (i)
            0:       return int'(acc_a);
            1:       return int'(acc_b);
            2:       return int'(acc_c);
            default: return int'(acc_d);
        endcase
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Sum of the current group's products, applying the wrap/clamp rule per addition.
    task automatic model_fold(input int i, output int acc, output int ovf);
        longint s;
        longint lim;
        lim = longint'(1) << ACCW_P[i];
        acc = 0;
        ovf = 0;
        for (int k = 0; k < grp_q[i].size(); k++) begin
            s = longint'(acc) + longint'(grp_q[i][k]);
            if (s >= lim) begin
                ovf = 1;
`ifdef PRODUCT_ACCUM_SAT_EN
                acc = int'(lim - 1);
`else
                acc = int'(s - lim);
`endif
            end else begin
                acc = int'(s);
            end
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                grp_q[i].delete();
                pend_q[i].delete();
                drop_m[i] = 1'b0;
            end else if (grp_q[i].size() == CNT_P[i]) begin
                if (out_ready) begin
                    grp_q[i].delete();
                    if (pend_q[i].size() > 0) begin
                        grp_q[i].push_back(pend_q[i].pop_front());
                        if (done) pend_q[i].push_back(int'(product));
                    end else if (done) begin
                        grp_q[i].push_back(int'(product));
                    end
                end else if (done) begin
                    if (pend_q[i].size() > 0) drop_m[i] = 1'b1;
                    else pend_q[i].push_back(int'(product));
                end
            end else if (done) begin
                grp_q[i].push_back(int'(product));
            end
        end
    endtask

    task automatic check_all();
        int ea;
        int eo;
        int sz;
        for (int i = 0; i < N; i++) begin
            model_fold(i, ea, eo);
            sz = grp_q[i].size();
            check_eq($sformatf("acc_out[%0d]", i), acc_of(i), ea);
            check_eq($sformatf("out_valid[%0d]", i), int'(ov_v[i]), int'(sz == CNT_P[i]));
            check_eq($sformatf("overflow[%0d]", i), int'(of_v[i]), eo);
            check_eq($sformatf("busy[%0d]", i), int'(bz_v[i]), int'(sz > 0 && sz < CNT_P[i]));
            check_eq($sformatf("drop_err[%0d]", i), int'(de_v[i]), int'(drop_m[i]));
        end
    endtask

    task automatic tick(input logic d, input int p, input logic r);
        done      = d;
        product   = p[7:0];
        out_ready = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0, 0, 1'b1);
        tick(1'b1, 99, 1'b1);
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        check_eq("reset_acc", int'(acc_a), 0);
        check_eq("reset_flags", int'({ov_v, of_v, bz_v, de_v}), 0);

        // Basic group of four.
        tick(1'b1, 32, 1'b1);
        check_eq("count1_acc", int'(acc_c), 32);
        tick(1'b1, 3, 1'b1);
        tick(1'b1, 225, 1'b1);
        tick(1'b1, 9, 1'b1);
        check_eq("sum269_acc", int'(acc_a), 269);
        check_eq("sum269_valid", int'(ov_v[0]), 1);
        check_eq("sum269_ovf", int'(of_v[0]), 0);
        tick(1'b0, 0, 1'b1);
        check_eq("sum269_valid_one_cycle", int'(ov_v[0]), 0);
        tick(1'b1, 144, 1'b1);
        check_eq("count1_144_acc", int'(acc_c), 144);
        check_eq("count1_144_valid", int'(ov_v[2]), 1);

        // Overflow in a 9-bit accumulator.
        do_reset();
        repeat (4) tick(1'b1, 255, 1'b1);
`ifdef PRODUCT_ACCUM_SAT_EN
        check_eq("acc9_sat", int'(acc_b), 511);
`else
        check_eq("acc9_wrap", int'(acc_b), 508);
`endif
        check_eq("acc9_ovf", int'(of_v[1]), 1);

        // Back-pressure: pending slot, then a drop.
        do_reset();
        tick(1'b1, 1, 1'b0);
        tick(1'b1, 2, 1'b0);
        tick(1'b1, 3, 1'b0);
        tick(1'b1, 4, 1'b0);
        tick(1'b1, 7, 1'b0);
        check_eq("hold_acc", int'(acc_a), 10);
        check_eq("hold_valid", int'(ov_v[0]), 1);
        tick(1'b0, 0, 1'b1);
        check_eq("pend_acc", int'(acc_a), 7);
        check_eq("pend_busy", int'(bz_v[0]), 1);
        check_eq("pend_nodrop", int'(de_v[0]), 0);
        repeat (3) tick(1'b1, 1, 1'b1);
        tick(1'b1, 7, 1'b0);
        tick(1'b1, 8, 1'b0);
        check_eq("drop_set", int'(de_v[0]), 1);
        tick(1'b0, 0, 1'b1);
        check_eq("drop_sticky", int'(de_v[0]), 1);
        check_eq("drop_pend_acc", int'(acc_a), 7);

        // Back-to-back groups of two.
        do_reset();
        tick(1'b1, 1, 1'b1);
        tick(1'b1, 2, 1'b1);
        check_eq("c2_first", int'(acc_d), 3);
        check_eq("c2_first_valid", int'(ov_v[3]), 1);
        tick(1'b1, 3, 1'b1);
        check_eq("c2_gap_valid", int'(ov_v[3]), 0);
        tick(1'b1, 4, 1'b1);
        check_eq("c2_second", int'(acc_d), 7);

        // Asynchronous reset mid-group.
        do_reset();
        tick(1'b1, 5, 1'b1);
        tick(1'b1, 6, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("async_rst_acc", int'(acc_a), 0);
        check_eq("async_rst_busy", int'(bz_v[0]), 0);
        tick(1'b1, 9, 1'b1);
        reset = 1'b1;
        repeat (4) tick(1'b1, 5, 1'b1);
        check_eq("after_rst_sum", int'(acc_a), 20);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            tick(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 1) == 1));
        end
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
